// File: rtl/dec64_pkg.sv
// rtl/dec64_pkg.sv - shared types and constants for the 64-line decoder arbiter
package dec64_pkg;

  localparam int DEC_AW    = 6;
  localparam int DEC_LINES = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/dec64_arbiter_rr_pick.sv
// rtl/dec64_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [PW-1:0]    win_idx_o,
  output logic             valid_o
);

  always_comb begin
    int k;
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    k         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o     = 1'b1;
        win_idx_o   = PW'(k);
        win_oh_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec64_arbiter.sv
// rtl/dec64_arbiter.sv - round-robin arbiter sharing one 6-to-64 decoder between N_REQ requesters
module dec64_arbiter
  import dec64_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = 6,
  parameter int HOLD  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr_i,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                dec_en,
  output logic [AW-1:0]       dec_w,
  output logic                busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD + 1);

  if (HOLD < 1) begin : g_bad_hold
    $error("dec64_arbiter: HOLD must be at least 1");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("dec64_arbiter: N_REQ must be in 2..8");
  end
  if (AW != DEC_AW) begin : g_bad_aw
    $error("dec64_arbiter: AW must match the decoder address width");
  end

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             dec_en_q;
  logic [AW-1:0]    dec_w_q;
  logic             busy_q;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic             holding;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // The winner keeps its slot only while its own request stays high.
  assign holding = |(req & gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      dec_en_q <= 1'b0;
      dec_w_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (pick_valid) begin
            state_q <= S_GRANT;
            gnt_q   <= pick_oh;
            win_q   <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          state_q  <= S_HOLD;
          dec_w_q  <= addr_i[win_q*AW +: AW];
          ptr_q    <= (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          cnt_q    <= CW'(HOLD);
          dec_en_q <= 1'b1;
          done_q   <= (HOLD == 1) ? gnt_q : '0;
        end
        S_HOLD: begin
          // Final cycle takes priority over abort: a transfer that reached
          // its done pulse is complete even if the request falls with it.
          if (cnt_q == CW'(1) || !holding) begin
            state_q  <= S_RELEASE;
            dec_en_q <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CW'(2)) ? gnt_q : '0;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign dec_en = dec_en_q;
  assign dec_w  = dec_w_q;
  assign busy   = busy_q;

endmodule
